// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM state type for the eight-input round-robin arbiter.
// Used by rr_pick8 and rr_arbiter_8.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: finds the first set bit of the
// eligible vector searching upward from the pointer, wrapping 7 -> 0.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic [IDX_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_rot_pick;
  logic [IDX_W-1:0] w_rot_idx;

  // Rotate right so that bit i_ptr becomes bit 0; plain fixed priority then
  // gives the round-robin order.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = i_elig[IDX_W'(i) + i_ptr];
    end
  end

  assign w_rot_pick = w_rot & (~w_rot + 1'b1);

  // NOTE: blocking assignments in combinational logic; the downward loop lets
  // the lowest set bit overwrite any higher one.
  always_comb begin
    w_rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rot_idx = IDX_W'(i);
    end
  end

  always_comb begin
    o_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_pick[IDX_W'(i) + i_ptr] = w_rot_pick[i];
    end
  end

  assign o_idx = w_rot_idx + i_ptr;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-input round-robin arbiter with registered one-hot grant and valid/ack
// handshake. Define RR_ARB_STICKY_EN to latch request rising edges as pending.
module rr_arbiter_8 #(
  parameter int N_REQ = rr_arb_pkg::N_REQ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid
);

  import rr_arb_pkg::IDX_W;
  import rr_arb_pkg::state_t;
  import rr_arb_pkg::ST_IDLE;
  import rr_arb_pkg::ST_GRANT;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_pick;
  logic [IDX_W-1:0] w_pick_idx;

`ifdef RR_ARB_STICKY_EN
  logic [N_REQ-1:0] r_req_q;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] w_set;
  logic [N_REQ-1:0] w_clr;

  assign w_set  = req & ~r_req_q;
  assign w_clr  = (r_state == ST_GRANT && ack) ? r_gnt : '0;
  assign w_elig = r_pending;

  // A set landing on the bit being cleared wins, so a fresh pulse survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= req;
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end
`else
  assign w_elig = req;
`endif

  rr_pick8 u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx)
  );

  // NOTE: every output of this block gets a default first so that no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_ptr_nxt       = r_ptr;
    w_idx_nxt       = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_nxt       = w_pick;
          w_gnt_valid_nxt = 1'b1;
          w_idx_nxt       = w_pick_idx;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          w_state_nxt     = ST_IDLE;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: asynchronous reset clears the grant immediately, keeping the
  // encoder input legal without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= '0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_ptr       <= w_ptr_nxt;
      r_idx       <= w_idx_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a behavioural model predicts each cycle's
// grant, a negedge monitor compares; directed scenarios then random traffic.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       ack = 1'b0;
  logic [7:0] gnt;
  logic       gnt_valid;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Reference model state: busy flag, holder index, search start, pending set.
  bit         m_busy;
  int         m_holder;
  int         m_ptr;
  logic [7:0] m_pend;
  logic [7:0] m_prev;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_holder = 0;
    m_ptr    = 0;
    m_pend   = 8'h00;
    m_prev   = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] r, input logic a);
    logic [7:0] elig;
    logic [7:0] clr;
    bit         found;
    int         idx;
    if (!rst_n) begin
      model_reset();
    end else begin
      clr = 8'h00;
`ifdef RR_ARB_STICKY_EN
      elig = m_pend;
`else
      elig = r;
`endif
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          idx = (m_ptr + k) % 8;
          if (!found && elig[idx]) begin
            found    = 1'b1;
            m_holder = idx;
            m_busy   = 1'b1;
          end
        end
      end else if (a) begin
        m_busy      = 1'b0;
        m_ptr       = (m_holder + 1) % 8;
        clr[m_holder] = 1'b1;
      end
      m_pend = (m_pend & ~clr) | (r & ~m_prev);
      m_prev = r;
    end
    exp_q.push_back({m_busy, m_busy ? 8'(1 << m_holder) : 8'h00});
  endtask

  task automatic cycle(input logic [7:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    model_step(r, a);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    cycle(8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt_valid", 32'(gnt_valid), 32'(e[8]));
      check("gnt", 32'(gnt), 32'(e[7:0]));
    end
  end

  always @(gnt or gnt_valid) begin
    if (started) begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("valid_matches_gnt", 32'(gnt_valid), 32'(gnt != 8'h00));
    end
  end

  initial begin
    model_reset();
    #2;
    rst_n = 1'b0;
    started = 1'b1;

    // Reset held with every requester active.
    repeat (3) cycle(8'hFF, 1'b0);
    check("gnt_in_reset", 32'(gnt), 32'h00);
    rst_n = 1'b1;
    cycle(8'hFF, 1'b0);
`ifdef RR_ARB_STICKY_EN
    check("first_grant_after_reset", 32'(gnt), 32'h00);
    cycle(8'hFF, 1'b0);
    check("first_grant_after_reset_sticky", 32'(gnt), 32'h01);
`else
    check("first_grant_after_reset", 32'(gnt), 32'h01);
`endif

    // Single requester, ack delayed, then re-grant via wrapped search.
    do_reset();
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b1);
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b1);
    cycle(8'h00, 1'b0);

    // All requesting with ack tied high.
    do_reset();
    repeat (18) cycle(8'hFF, 1'b1);

    // Wrap-around after granting index 2.
    do_reset();
    cycle(8'h04, 1'b0);
    cycle(8'h04, 1'b1);
    cycle(8'h05, 1'b0);
`ifndef RR_ARB_STICKY_EN
    check("wrap_grant", 32'(gnt), 32'h01);
`endif
    cycle(8'h05, 1'b1);
    cycle(8'h05, 1'b0);
    cycle(8'h00, 1'b1);

    // Grant frozen while requests change.
    do_reset();
    cycle(8'h02, 1'b0);
    repeat (3) cycle(8'h40, 1'b0);
    cycle(8'h40, 1'b1);
    cycle(8'h40, 1'b0);
    cycle(8'h40, 1'b0);
    cycle(8'h00, 1'b1);

    // One-cycle pulse on req[5] during a grant of requester 0.
    do_reset();
    cycle(8'h01, 1'b0);
    cycle(8'h01, 1'b0);
    cycle(8'h21, 1'b0);
    cycle(8'h01, 1'b1);
    cycle(8'h00, 1'b0);
`ifdef RR_ARB_STICKY_EN
    check("pulse_followup", 32'(gnt), 32'h20);
`else
    check("pulse_followup", 32'(gnt), 32'h00);
`endif
    cycle(8'h00, 1'b1);

    // Asynchronous reset in the middle of a grant.
    cycle(8'h80, 1'b0);
    cycle(8'h80, 1'b0);
    check("granted_before_async_reset", 32'(gnt_valid), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_gnt", 32'(gnt), 32'h00);
    check("async_reset_valid", 32'(gnt_valid), 32'd0);
    cycle(8'h80, 1'b0);
    rst_n = 1'b1;

    // Random traffic.
    repeat (400) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      cycle(r, 1'($urandom_range(0, 1)));
    end

    cycle(8'h00, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
